// File: rtl/seg7_pkg.sv
// Shared constants, state type and width helper for the 7-segment scan driver.
// Glyphs are abcdefg, active-low (0 = segment lit).
package seg7_pkg;

    localparam logic [6:0] GLYPH_0 = 7'b0000001;
    localparam logic [6:0] GLYPH_1 = 7'b1001111;
    localparam logic [6:0] GLYPH_2 = 7'b0010010;
    localparam logic [6:0] GLYPH_3 = 7'b0000110;
    localparam logic [6:0] GLYPH_4 = 7'b1001100;
    localparam logic [6:0] GLYPH_5 = 7'b0100100;
    localparam logic [6:0] GLYPH_6 = 7'b0100000;
    localparam logic [6:0] GLYPH_7 = 7'b0001111;
    localparam logic [6:0] GLYPH_8 = 7'b0000000;
    localparam logic [6:0] GLYPH_9 = 7'b0000100;
    localparam logic [6:0] GLYPH_A = 7'b0001000;
    localparam logic [6:0] GLYPH_B = 7'b1100000;
    localparam logic [6:0] GLYPH_C = 7'b0110001;
    localparam logic [6:0] GLYPH_D = 7'b1000010;
    localparam logic [6:0] GLYPH_E = 7'b0110000;
    localparam logic [6:0] GLYPH_F = 7'b0111000;

    // All segments and the decimal point off.
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    typedef enum logic {ST_ACTIVE, ST_BLANK} seg7_state_e;

    // Ceiling log2; returns 0 for values <= 1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned width;
        width = 0;
        while ((64'd1 << width) < 64'(value)) width++;
        return width;
    endfunction

endpackage

// File: rtl/seg7_glyph_rom.sv
// Nibble-to-segment decoder: returns {a,b,c,d,e,f,g,dp}, active-low.
// A set blank input forces every segment off.
module seg7_glyph_rom
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    input  logic       blank,
    output logic [7:0] pattern
);

    logic [6:0] glyph;

    // Hex lookup, then merge the decimal point and blanking.
    always_comb begin
        glyph = GLYPH_8;
        unique case (nibble)
            4'h0: glyph = GLYPH_0;
            4'h1: glyph = GLYPH_1;
            4'h2: glyph = GLYPH_2;
            4'h3: glyph = GLYPH_3;
            4'h4: glyph = GLYPH_4;
            4'h5: glyph = GLYPH_5;
            4'h6: glyph = GLYPH_6;
            4'h7: glyph = GLYPH_7;
            4'h8: glyph = GLYPH_8;
            4'h9: glyph = GLYPH_9;
            4'hA: glyph = GLYPH_A;
            4'hB: glyph = GLYPH_B;
            4'hC: glyph = GLYPH_C;
            4'hD: glyph = GLYPH_D;
            4'hE: glyph = GLYPH_E;
            4'hF: glyph = GLYPH_F;
        endcase
        pattern = blank ? SEG_BLANK : {glyph, ~dp};
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver with per-slot dead time.
// Inputs are captured into a pending register on load and promoted to the
// displayed shadow register only at frame boundaries, so frames never tear.
// Optional build macro: SEG7_LZS_EN enables leading-zero suppression.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 8,
    parameter int unsigned SCAN_DIV     = 50000,
    parameter int unsigned BLANK_CYCLES = 500
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] data,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic                    load,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [7:0]              seg,
    output logic                    frame_start
);

    localparam int unsigned CW = (clog2(SCAN_DIV) < 1) ? 1 : clog2(SCAN_DIV);
    localparam int unsigned IW = (clog2(NUM_DIGITS) < 1) ? 1 : clog2(NUM_DIGITS);
    localparam logic [CW-1:0] CNT_LAST     = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_ACT_LAST = CW'(SCAN_DIV - BLANK_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST     = IW'(NUM_DIGITS - 1);

    logic [CW-1:0]           cnt_q;
    logic [IW-1:0]           idx_q;
    seg7_state_e             state_q;
    logic [4*NUM_DIGITS-1:0] pend_data_q, shadow_data_q, src_data;
    logic [NUM_DIGITS-1:0]   pend_dp_q, shadow_dp_q, src_dp;
    logic [NUM_DIGITS-1:0]   pend_en_q, shadow_en_q, src_en, src_en_eff;
    logic [NUM_DIGITS-1:0]   an_sel;
    logic [3:0]              cur_nibble;
    logic                    cur_dp, cur_en, cur_blank, frame_wrap;
    logic [7:0]              glyph_seg;

    assign frame_wrap = (cnt_q == CNT_LAST) && (idx_q == IDX_LAST);

    // A load coinciding with the frame boundary bypasses pending straight to shadow.
    assign src_data = load ? data     : pend_data_q;
    assign src_dp   = load ? dp_in    : pend_dp_q;
    assign src_en   = load ? digit_en : pend_en_q;

`ifdef SEG7_LZS_EN
    logic lzs_run;

    // Blank leading zero digits from the top down; digit 0 always survives.
    always_comb begin
        lzs_run    = 1'b1;
        src_en_eff = src_en;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            if (lzs_run) begin
                if ((src_data[4*i +: 4] != 4'h0) || src_dp[i]) begin
                    lzs_run = 1'b0;
                end else begin
                    src_en_eff[i] = 1'b0;
                end
            end
        end
    end
`else
    assign src_en_eff = src_en;
`endif

    // Pending capture on load; shadow promotion at the frame boundary.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_data_q   <= '0;
            pend_dp_q     <= '0;
            pend_en_q     <= '0;
            shadow_data_q <= '0;
            shadow_dp_q   <= '0;
            shadow_en_q   <= '0;
        end else begin
            if (load) begin
                pend_data_q <= data;
                pend_dp_q   <= dp_in;
                pend_en_q   <= digit_en;
            end
            if (frame_wrap) begin
                shadow_data_q <= src_data;
                shadow_dp_q   <= src_dp;
                shadow_en_q   <= src_en_eff;
            end
        end
    end

    // Select the current digit's nibble, dp, enable and anode position.
    always_comb begin
        cur_nibble = 4'h0;
        cur_dp     = 1'b0;
        cur_en     = 1'b0;
        an_sel     = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                cur_nibble = shadow_data_q[4*i +: 4];
                cur_dp     = shadow_dp_q[i];
                cur_en     = shadow_en_q[i];
                an_sel[i]  = 1'b0;
            end
        end
        cur_blank = (state_q != ST_ACTIVE) || !cur_en;
    end

    seg7_glyph_rom u_glyph_rom (
        .nibble  (cur_nibble),
        .dp      (cur_dp),
        .blank   (cur_blank),
        .pattern (glyph_seg)
    );

    // Slot counter, digit index, active/blank FSM and registered pin outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            idx_q       <= '0;
            state_q     <= ST_ACTIVE;
            an          <= '1;
            seg         <= SEG_BLANK;
            frame_start <= 1'b0;
        end else begin
            an          <= cur_blank ? '1 : an_sel;
            seg         <= glyph_seg;
            frame_start <= (cnt_q == '0) && (idx_q == '0);
            if (cnt_q == CNT_LAST) begin
                cnt_q   <= '0;
                state_q <= ST_ACTIVE;
                idx_q   <= (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
            end else begin
                cnt_q <= cnt_q + CW'(1);
                // With no blank phase CNT_ACT_LAST equals CNT_LAST, caught above.
                if (cnt_q == CNT_ACT_LAST) begin
                    state_q <= ST_BLANK;
                end
            end
        end
    end

endmodule
